// File: rtl/adder_pkg.sv
// Shared types and helpers for the byte-serial wide adder wrapper.
package adder_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Pick byte idx out of a vector zero-extended to the maximum operand width.
  function automatic logic [BYTE_W-1:0] byte_sel(
    input logic [BYTE_W*MAX_NBYTES-1:0] vec,
    input logic [4:0]                   idx
  );
    return vec[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshakes plus the byte lane to the external 8-bit adder.
interface wide_add_sequencer_if import adder_pkg::*; #(
  parameter int NBYTES = 4
) ();

  localparam int W = BYTE_W * NBYTES;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              op_sub;
  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic              add_cin;
  logic [BYTE_W-1:0] add_s;
  logic              add_cout;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      result;
  logic              carry_out;
  logic              ovf;

  modport slave (
    input  in_valid, op_a, op_b, op_sub, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, ovf
  );

  modport master (
    output in_valid, op_a, op_b, op_sub, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, ovf
  );

endinterface

// File: rtl/adder_top.sv
// Registered 8-bit ripple adder stage: sum and carry appear one edge after inputs.
module adder_top (
  input  logic       clk,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // NOTE: pure pipeline register with no reset; its contents are only consumed
  // once valid data has been pushed through, so a reset would buy nothing.
  always_ff @(posedge clk) begin
    {cout, s} <= {1'b0, a} + {1'b0, b} + {8'b0, cin};
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Streams two wide operands LSB byte first through an external registered
// 8-bit adder, chaining carry, and returns the wide sum/difference.
module wide_add_sequencer import adder_pkg::*; #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wide_add_sequencer_if.slave bus
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES + 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [IDX_W-1:0]         idx;
  logic [W-1:0]             a_q;
  logic [W-1:0]             b_q;
  logic                     sub_q;
  logic [W-1:0]             result_q;
  logic                     carry_q;
  logic                     ovf_q;
  logic                     last_byte;
  logic [BYTE_W*MAX_NBYTES-1:0] a_ext;
  logic [BYTE_W*MAX_NBYTES-1:0] b_ext;

  assign last_byte = (idx == IDX_W'(NBYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it lives inside the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path through
  // the case leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_byte)     state_nxt = DRAIN;
      DRAIN:                      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            sub_q <= bus.op_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          idx <= idx + IDX_W'(1);
          // The adder output seen while driving byte idx belongs to byte idx-1.
          for (int k = 0; k < NBYTES - 1; k++) begin
            if (idx == IDX_W'(k + 1)) result_q[k*BYTE_W +: BYTE_W] <= bus.add_s;
          end
        end
        DRAIN: begin
          result_q[(NBYTES-1)*BYTE_W +: BYTE_W] <= bus.add_s;
          carry_q <= bus.add_cout;
          ovf_q   <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                     (bus.add_s[BYTE_W-1] != a_q[W-1]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_ext       = '0;
    b_ext       = '0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state == RUN) begin
      a_ext[W-1:0] = a_q;
      b_ext[W-1:0] = b_q;
      bus.add_a    = byte_sel(a_ext, 5'(idx));
      bus.add_b    = byte_sel(b_ext, 5'(idx)) ^ {BYTE_W{sub_q}};
      bus.add_cin  = (idx == '0) ? sub_q : bus.add_cout;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: wide_add_sequencer paired with adder_top, checked
// against an arithmetic reference model plus hand-computed cases.
module tb_wide_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] last_b0;
  logic       last_cin;

  exp_t exp_q[$];

  wide_add_sequencer_if #(.NBYTES(NB)) bus ();

  wide_add_sequencer #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  adder_top u_adder (
    .clk  (clk),
    .a    (bus.add_a),
    .b    (bus.add_b),
    .cin  (bus.add_cin),
    .s    (bus.add_s),
    .cout (bus.add_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and signed-overflow rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    logic [W:0] full;
    if (sub) full = {1'b0, a} - {1'b0, b} + (1 << W);
    else     full = {1'b0, a} + {1'b0, b};
    e.r = full[W-1:0];
    e.c = full[W];
    if (sub) e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    else     e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction

  // Compare process: inputs change just after posedge, so the negedge sees
  // settled outputs and the inputs that the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("in_ready_out_valid_exclusive", {63'b0, bus.in_ready & bus.out_valid}, 64'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          check("result",    bus.result,    exp_q[0].r);
          check("carry_out", bus.carry_out, exp_q[0].c);
          check("ovf",       bus.ovf,       exp_q[0].o);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op_a, bus.op_b, bus.op_sub));
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int hold, input bit lit,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    check("in_ready_before_op", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    step();
    bus.in_valid = 1'b0;
    last_b0  = bus.add_b;
    last_cin = bus.add_cin;
    check("first_add_a",   bus.add_a,   a[7:0]);
    check("first_add_b",   bus.add_b,   b[7:0] ^ {8{sub}});
    check("first_add_cin", bus.add_cin, sub);
    n = 0;
    while (!bus.out_valid && n < 50) begin step(); n++; end
    check("latency_edges", n, NB + 1);
    if (lit) begin
      check("lit_result", bus.result,    er);
      check("lit_carry",  bus.carry_out, ec);
      check("lit_ovf",    bus.ovf,       eo);
    end
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      bus.op_sub   = 1'($urandom_range(0, 1));
      step();
      check("busy_in_ready",  bus.in_ready,  1'b0);
      check("busy_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("release_in_ready",  bus.in_ready,  1'b1);
    check("release_out_valid", bus.out_valid, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_result"},    bus.result,    '0);
    check({tag, "_carry"},     bus.carry_out, 1'b0);
    check({tag, "_ovf"},       bus.ovf,       1'b0);
    check({tag, "_add_a"},     bus.add_a,     8'h00);
    check({tag, "_add_b"},     bus.add_b,     8'h00);
    check({tag, "_add_cin"},   bus.add_cin,   1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", bus.in_ready, 1'b1);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("sub_byte0_add_b",   last_b0,  8'hF8);
    check("sub_byte0_add_cin", last_cin, 1'b1);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 10, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    // Abort mid-RUN with idx=2.
    bus.in_valid = 1'b1;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'h1234_5678;
    bus.op_sub   = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_reset_values("midrun_reset");
    rst_n = 1'b1;
    step();
    check("in_ready_after_abort", bus.in_ready, 1'b1);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = '1;
        1:       ra = 32'h8000_0000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = '1;
        1:       rb = '0;
        default: rb = W'($urandom);
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
